tf_chan_rx: RTL
===============

# tf_chan_rx

Synchronous receiver for the tokenflow 4-phase bundled-data output channel. It synchronises the asynchronous `req`, captures the bundled data into a small FIFO, and returns `ack` only when the word is stored. This gives the clocked fabric a valid/ready stream with backpressure. It sits directly downstream of the tokenflow generator and replaces tying `ack` to a pad.

## Interface
- `W`, 15: data width, matching the tokenflow channel data field.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SYNC`, 2: synchroniser flop stages on `in_req`; ≥2.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high.
- `in_req`  in  1  tokenflow request; asynchronous, 4-phase.
- `in_data`  in  W  bundled data; stable from before `in_req` rises until `in_ack` rises.
- `in_ack`  out  1  acknowledge; registered.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head when `out_valid` is also high.
- `out_data`  out  W  FIFO head word.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `seq_err`  out  1  sticky sequence error; see Configuration.

## Operation
- `req_s` is `in_req` after `SYNC` flops, all cleared by reset.
- FSM states:
  - IDLE (`in_ack`=0): if `req_s`=1 and `level`<`DEPTH` at the start of the cycle, then at the clock edge push `in_data`, set `in_ack`=1, and go to WAIT_LO. Otherwise stay in IDLE.
  - WAIT_LO (`in_ack`=1): if `req_s`=0, clear `in_ack` and go to IDLE.
- Push is gated on the registered `level` only. A pop in the same cycle does not enable a push when full; the push happens one cycle later.
- Pop occurs when `out_valid`&&`out_ready`. Simultaneous push and pop leaves `level` unchanged.
- FIFO: circular read/write pointers of log2(DEPTH) bits that wrap naturally. `out_data` is the head entry. `out_data` is don't-care when `out_valid`=0.
- Full: `in_ack` stays 0, so the producer stalls holding `req`. No word is lost and nothing is overwritten.
- Empty: `out_valid`=0, and `out_ready` is ignored.
- Reset values: `in_ack`=0, `out_valid`=0, `level`=0, `seq_err`=0, state IDLE, pointers 0.
- Reset is applied together with the tokenflow reset. If `req_s`=1 after reset, it is treated as a new token.
- Mid-handshake reset drops any half-done handshake and empties the FIFO.

## Timing
- `in_req` rise to push and `in_ack` rise: `SYNC`+1 clock edges if not full (the extra edge is the FSM register). The bound is ±1 edge from asynchronous sampling.
- Data is sampled `SYNC` cycles after `req` is seen. This relies on the bundled-data constraint: data is settled before `req` rises.
- `in_req` fall to `in_ack` fall: `SYNC`+1 edges.
- Push to `out_valid`=1: `out_valid` is high in the next cycle (no FIFO bypass).
- Maximum throughput: one word per 2·(`SYNC`+1) cycles plus producer delay.
- Pop effect: `level` decrements at the pop edge; a full FIFO accepts a push one cycle after the pop.

## Configuration
- `TF_RX_SEQ_CHECK_EN` defined: a checker is compiled in for the tokenflow pronic sequence 0, 2, 6, 12, 20, …, n(n+1), computed mod 2^W.
  - It keeps `exp` (reset 0) and `step` (reset 2).
  - On each push: if `in_data`≠`exp`, set `seq_err`=1 (sticky until reset). Then update `exp`+=`step` and `step`+=2, whether or not the word matched.
- `TF_RX_SEQ_CHECK_EN` undefined: no checker logic is built, and `seq_err` is tied to 0.

## Test plan
- Single token, SYNC=2: raise `in_req` with `in_data`=0x0000 and `out_ready`=0.
  - `in_ack` rises 3±1 edges later; `out_valid`=1 next cycle with `out_data`=0x0000 and `level`=1.
  - Drop `in_req`: `in_ack` falls 3±1 edges later.
- Stream: tokenflow model responding to `in_ack`, with `out_ready`=1 throughout.
  - `out_data` sequence is 0, 2, 6, 12, 20, 30; `level` never exceeds 1; `seq_err`=0 with the macro defined.
- Backpressure: `out_ready`=0 for 5 tokens, DEPTH=4.
  - `level` reaches 4 and `in_ack` stays 0 on the 5th token while `in_req` is held.
  - One pop: 5th word pushed one cycle after `level` shows 3; pop order 0, 2, 6, 12, 20.
- Simultaneous push/pop with `level`=2: `level` stays 2, and the head advances by one word.
- Sequence error (macro defined): inject 7 in place of 6.
  - `seq_err`=1 one cycle after that push and stays 1 after the correct word 12 arrives; reset clears it.
- Reset during WAIT_LO with `level`=3:
  - Next cycle: `in_ack`=0, `level`=0, `out_valid`=0.
  - With `in_req` still high, a new push happens `SYNC`+1 edges after reset deasserts.

Source files
------------

// File: rtl/tf_chan_rx.sv
// tf_chan_rx: synchronous receiver for the tokenflow 4-phase bundled-data channel.
// Define TF_RX_SEQ_CHECK_EN to build the pronic-sequence checker that drives seq_err.
module tf_chan_rx #(
  parameter int W     = 15,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_req,
  input  logic [W-1:0]                 in_data,
  output logic                         in_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_e;

  logic [SYNC-1:0] sync_q;
  logic            req_s;
  state_e          state_q, state_d;
  logic            ack_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic            push, pop;

  assign req_s = sync_q[SYNC-1];
  assign pop   = (level_q != '0) && out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gate on registered occupancy only; a same-cycle pop does not free a slot.
        if (req_s && (level_q < LW'(DEPTH))) begin
          push    = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC-2:0], in_req};
      state_q <= state_d;
      ack_q   <= (state_d == WAIT_LO);
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ack    = ack_q;
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;

`ifdef TF_RX_SEQ_CHECK_EN
  logic [W-1:0] exp_q, step_q;
  logic         err_q;

  // Pronic sequence n(n+1): successive differences are 2, 4, 6, ...
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q  <= '0;
      step_q <= W'(2);
      err_q  <= 1'b0;
    end else if (push) begin
      if (in_data != exp_q) err_q <= 1'b1;
      exp_q  <= exp_q + step_q;
      step_q <= step_q + W'(2);
    end
  end

  assign seq_err = err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule
